// File: rtl/axis_pingpong_ctrl.sv
// axis_pingpong_ctrl: ping-pong controller that steers an AXI-Stream into two
// external BRAM banks and drains them to a downstream AXI-Stream.
// Each bank holds one packet of up to DD beats. While one bank is written, the
// other bank can be read, so the sustained rate is one beat per cycle.
// Optional feature: define AXIS_PP_FLUSH_EN to add the 'flush' input. A flush
// closes a partially filled write bank early and marks it as end of packet.
module axis_pingpong_ctrl #(
  parameter int DD = 2048,
  parameter int AW = $clog2(DD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
`ifdef AXIS_PP_FLUSH_EN
  input  logic          flush,
`endif
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [1:0]    bank_full
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DD - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  bank_state_e   bankState_q [2];
  logic [CW-1:0] bankLen_q   [2];
  logic          bankLast_q  [2];
  logic          wrBank_q;
  logic          rdBank_q;
  logic [CW-1:0] wrCnt_q;
  logic [CW-1:0] rdCnt_q;
  logic          mValid_q;
  logic          mLast_q;

  logic          wrOpen;
  logic          rdOpen;
  logic          accept;
  logic          flushClose;
  logic          closeBank;
  logic          closeLast;
  logic [CW-1:0] closeLen;
  logic          rdIssue;
  logic          rdFinal;

  // Decode the bank states into write/read permissions and drive the strobes.
  // Outputs are masked by rst so everything reads idle for the whole reset.
  always_comb begin
    wrOpen     = (bankState_q[wrBank_q] == EMPTY) || (bankState_q[wrBank_q] == FILLING);
    rdOpen     = (bankState_q[rdBank_q] == FULL) || (bankState_q[rdBank_q] == DRAINING);
    s_tready   = !rst && wrOpen;
    accept     = s_tvalid && s_tready;
    flushClose = 1'b0;
`ifdef AXIS_PP_FLUSH_EN
    flushClose = !rst && flush && (bankState_q[wrBank_q] == FILLING) && (wrCnt_q != '0);
`endif
    closeBank  = (accept && (s_tlast || (wrCnt_q == LAST_IDX))) || flushClose;
    closeLast  = flushClose || s_tlast;
    closeLen   = wrCnt_q + CW'(accept);
    rdIssue    = !rst && rdOpen && (!mValid_q || m_tready);
    rdFinal    = (rdCnt_q == (bankLen_q[rdBank_q] - CW'(1)));

    wr_en      = accept;
    wr_bank    = wrBank_q;
    wr_addr    = wrCnt_q[AW-1:0];
    rd_en      = rdIssue;
    rd_bank    = rdBank_q;
    rd_addr    = rdCnt_q[AW-1:0];
    m_tvalid   = mValid_q && !rst;
    m_tlast    = mLast_q && !rst;
    bank_full[0] = !rst && ((bankState_q[0] == FULL) || (bankState_q[0] == DRAINING));
    bank_full[1] = !rst && ((bankState_q[1] == FULL) || (bankState_q[1] == DRAINING));
  end

  // Bank state machines, write/read pointers and the registered output beat.
  // The writer only touches an EMPTY/FILLING bank and the reader only a
  // FULL/DRAINING bank, so the two sides never update the same bank together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        bankState_q[i] <= EMPTY;
        bankLen_q[i]   <= '0;
        bankLast_q[i]  <= 1'b0;
      end
      wrBank_q <= 1'b0;
      rdBank_q <= 1'b0;
      wrCnt_q  <= '0;
      rdCnt_q  <= '0;
      mValid_q <= 1'b0;
      mLast_q  <= 1'b0;
    end else begin
      if (wrOpen) begin
        if (closeBank) begin
          bankState_q[wrBank_q] <= FULL;
          bankLen_q[wrBank_q]   <= closeLen;
          bankLast_q[wrBank_q]  <= closeLast;
          wrBank_q              <= !wrBank_q;
          wrCnt_q               <= '0;
        end else begin
          if (bankState_q[wrBank_q] == EMPTY) begin
            bankState_q[wrBank_q] <= FILLING;
          end
          if (accept) begin
            wrCnt_q <= wrCnt_q + CW'(1);
          end
        end
      end

      if (rdIssue) begin
        if (rdFinal) begin
          bankState_q[rdBank_q] <= EMPTY;
          rdBank_q              <= !rdBank_q;
          rdCnt_q               <= '0;
        end else begin
          bankState_q[rdBank_q] <= DRAINING;
          rdCnt_q               <= rdCnt_q + CW'(1);
        end
      end

      if (rdIssue) begin
        mValid_q <= 1'b1;
        mLast_q  <= rdFinal && bankLast_q[rdBank_q];
      end else if (m_tready) begin
        mValid_q <= 1'b0;
        mLast_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pingpong_ctrl.sv
// tb_axis_pingpong_ctrl: directed, self-checking bench for axis_pingpong_ctrl
// with DD=8. A short packet is checked cycle by cycle from a vector table;
// bank overflow/stall, drain order, streaming, mid-transfer reset and (when
// AXIS_PP_FLUSH_EN is defined) flush are checked by hand-written sequences.
module tb_axis_pingpong_ctrl;

  localparam int DD = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          flushIn;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [1:0]    bank_full;

  int checkCount;
  int errCount;

  typedef struct {
    logic       sv;
    logic       sl;
    logic       mr;
    logic       eTready;
    logic       eWrEn;
    logic       eWrBank;
    logic [2:0] eWrAddr;
    logic       eRdEn;
    logic       eRdBank;
    logic [2:0] eRdAddr;
    logic       eMValid;
    logic       eMLast;
    logic [1:0] eBankFull;
  } vec_t;

  vec_t shortPkt [8];

  axis_pingpong_ctrl #(.DD(DD), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
`ifdef AXIS_PP_FLUSH_EN
    .flush     (flushIn),
`endif
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_bank   (rd_bank),
    .rd_addr   (rd_addr),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .bank_full (bank_full)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic sv, input logic sl, input logic mr,
                                 input logic tr, input logic we, input logic wb,
                                 input logic [2:0] wa, input logic re, input logic rb,
                                 input logic [2:0] ra, input logic mv, input logic ml,
                                 input logic [1:0] bf);
    vec_t v;
    v.sv = sv; v.sl = sl; v.mr = mr;
    v.eTready = tr; v.eWrEn = we; v.eWrBank = wb; v.eWrAddr = wa;
    v.eRdEn = re; v.eRdBank = rb; v.eRdAddr = ra;
    v.eMValid = mv; v.eMLast = ml; v.eBankFull = bf;
    return v;
  endfunction

  task automatic applyStimulus(input logic sv, input logic sl, input logic mr);
    s_tvalid = sv;
    s_tlast  = sl;
    m_tready = mr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for two edges with upstream traffic offered, check that every
  // output reads idle, then release reset.
  task automatic doReset();
    rst = 1'b1;
    flushIn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_s_tready", s_tready, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_m_tvalid", m_tvalid, 0);
    checkOutput("rst_m_tlast", m_tlast, 0);
    checkOutput("rst_bank_full", bank_full, 0);
    checkOutput("rst_wr_bank", wr_bank, 0);
    checkOutput("rst_rd_bank", rd_bank, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  // Main test sequence.
  initial begin
    int expRdBank;
    checkCount = 0;
    errCount   = 0;
    rst        = 1'b1;
    flushIn    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // 3-beat packet with tlast on beat 3, downstream always ready.
    shortPkt[0] = mkVec(1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,3'd0, 1'b0,1'b0,3'd0, 1'b0,1'b0,2'b00);
    shortPkt[1] = mkVec(1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,3'd1, 1'b0,1'b0,3'd0, 1'b0,1'b0,2'b00);
    shortPkt[2] = mkVec(1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,3'd2, 1'b0,1'b0,3'd0, 1'b0,1'b0,2'b00);
    shortPkt[3] = mkVec(1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,3'd0, 1'b1,1'b0,3'd0, 1'b0,1'b0,2'b01);
    shortPkt[4] = mkVec(1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,3'd0, 1'b1,1'b0,3'd1, 1'b1,1'b0,2'b01);
    shortPkt[5] = mkVec(1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,3'd0, 1'b1,1'b0,3'd2, 1'b1,1'b0,2'b01);
    shortPkt[6] = mkVec(1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,3'd0, 1'b0,1'b1,3'd0, 1'b1,1'b1,2'b00);
    shortPkt[7] = mkVec(1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,3'd0, 1'b0,1'b1,3'd0, 1'b0,1'b0,2'b00);

    $display("[TB] short packet");
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(shortPkt[i].sv, shortPkt[i].sl, shortPkt[i].mr);
      #1;
      checkOutput("pkt_s_tready", s_tready, shortPkt[i].eTready);
      checkOutput("pkt_wr_en", wr_en, shortPkt[i].eWrEn);
      checkOutput("pkt_wr_bank", wr_bank, shortPkt[i].eWrBank);
      checkOutput("pkt_wr_addr", wr_addr, shortPkt[i].eWrAddr);
      checkOutput("pkt_rd_en", rd_en, shortPkt[i].eRdEn);
      checkOutput("pkt_rd_bank", rd_bank, shortPkt[i].eRdBank);
      checkOutput("pkt_rd_addr", rd_addr, shortPkt[i].eRdAddr);
      checkOutput("pkt_m_tvalid", m_tvalid, shortPkt[i].eMValid);
      checkOutput("pkt_m_tlast", m_tlast, shortPkt[i].eMLast);
      checkOutput("pkt_bank_full", bank_full, shortPkt[i].eBankFull);
      stepCycle();
    end

    // 20 beats, no tlast, downstream stalled: both banks fill and the
    // upstream is back-pressured from beat 17 on.
    $display("[TB] fill both banks with stalled output");
    doReset();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      #1;
      if (k < 16) begin
        checkOutput("fill_s_tready", s_tready, 1);
        checkOutput("fill_wr_en", wr_en, 1);
        checkOutput("fill_wr_bank", wr_bank, k / 8);
        checkOutput("fill_wr_addr", wr_addr, k % 8);
      end else begin
        checkOutput("stall_s_tready", s_tready, 0);
        checkOutput("stall_wr_en", wr_en, 0);
      end
      checkOutput("fill_bank_full", bank_full, (k < 8) ? 0 : ((k < 16) ? 1 : 3));
      checkOutput("fill_rd_en", rd_en, k == 8);
      checkOutput("fill_rd_addr", rd_addr, (k >= 9) ? 1 : 0);
      checkOutput("fill_m_tvalid", m_tvalid, k >= 9);
      checkOutput("fill_m_tlast", m_tlast, 0);
      stepCycle();
    end

    // Release the downstream: 16 beats leave in order, bank A then bank B,
    // and the pending upstream beats resume once bank A is empty.
    $display("[TB] drain both banks");
    for (int r = 0; r < 18; r++) begin
      applyStimulus(r <= 10, 1'b0, 1'b1);
      #1;
      checkOutput("drain_rd_en", rd_en, r <= 14);
      checkOutput("drain_rd_bank", rd_bank, (r >= 7 && r <= 14) ? 1 : 0);
      if (r <= 14) begin
        checkOutput("drain_rd_addr", rd_addr, (r <= 6) ? r + 1 : r - 7);
      end
      checkOutput("drain_m_tvalid", m_tvalid, r <= 15);
      checkOutput("drain_m_tlast", m_tlast, 0);
      checkOutput("drain_s_tready", s_tready, r >= 7);
      checkOutput("drain_wr_en", wr_en, r >= 7 && r <= 10);
      if (r >= 7 && r <= 10) begin
        checkOutput("drain_wr_addr", wr_addr, r - 7);
        checkOutput("drain_wr_bank", wr_bank, 0);
      end
      checkOutput("drain_bank_full", bank_full, (r <= 6) ? 3 : ((r <= 14) ? 2 : 0));
      stepCycle();
    end

    // Continuous 4-beat packets: one beat in and one beat out every cycle,
    // with the write and read banks always opposite once both are active.
    $display("[TB] streaming 4-beat packets");
    doReset();
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, (k % 4) == 3, 1'b1);
      #1;
      expRdBank = ((k - 4) / 4) % 2;
      checkOutput("stream_s_tready", s_tready, 1);
      checkOutput("stream_wr_en", wr_en, 1);
      checkOutput("stream_wr_addr", wr_addr, k % 4);
      checkOutput("stream_wr_bank", wr_bank, (k / 4) % 2);
      checkOutput("stream_rd_en", rd_en, k >= 4);
      if (k >= 4) begin
        checkOutput("stream_rd_bank", rd_bank, expRdBank);
        checkOutput("stream_rd_addr", rd_addr, k % 4);
        checkOutput("stream_bank_sep", wr_bank != rd_bank, 1);
        checkOutput("stream_bank_full", bank_full, 1 << expRdBank);
      end
      checkOutput("stream_m_tvalid", m_tvalid, k >= 5);
      checkOutput("stream_m_tlast", m_tlast, (k >= 8) && ((k % 4) == 0));
      stepCycle();
    end

    // Reset in the middle of draining bank A; nothing of the old packet may
    // reappear afterwards.
    $display("[TB] reset while draining");
    doReset();
    for (int k = 0; k < 11; k++) begin
      applyStimulus(k < 8, k == 7, 1'b1);
      #1;
      checkOutput("mid_wr_en", wr_en, k < 8);
      checkOutput("mid_rd_en", rd_en, k >= 8);
      if (k >= 8) begin
        checkOutput("mid_rd_addr", rd_addr, k - 8);
      end
      checkOutput("mid_m_tvalid", m_tvalid, k >= 9);
      stepCycle();
    end
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput("midrst_m_tvalid", m_tvalid, 0);
      checkOutput("midrst_rd_en", rd_en, 0);
      checkOutput("midrst_s_tready", s_tready, 0);
      checkOutput("midrst_bank_full", bank_full, 0);
      stepCycle();
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("post_s_tready", s_tready, 1);
      checkOutput("post_m_tvalid", m_tvalid, 0);
      checkOutput("post_m_tlast", m_tlast, 0);
      checkOutput("post_rd_en", rd_en, 0);
      checkOutput("post_bank_full", bank_full, 0);
      checkOutput("post_wr_bank", wr_bank, 0);
      stepCycle();
    end

`ifdef AXIS_PP_FLUSH_EN
    // Two beats then a flush close bank A as a 2-beat packet with tlast;
    // a flush on the fresh, empty bank B changes nothing.
    $display("[TB] flush");
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k < 2, 1'b0, 1'b1);
      flushIn = (k == 2) || (k == 6);
      #1;
      checkOutput("flush_wr_en", wr_en, k < 2);
      checkOutput("flush_rd_en", rd_en, k == 3 || k == 4);
      if (k == 3 || k == 4) begin
        checkOutput("flush_rd_addr", rd_addr, k - 3);
      end
      checkOutput("flush_m_tvalid", m_tvalid, k == 4 || k == 5);
      checkOutput("flush_m_tlast", m_tlast, k == 5);
      checkOutput("flush_bank_full", bank_full, (k >= 3 && k <= 4) ? 1 : 0);
      checkOutput("flush_wr_bank", wr_bank, k >= 3);
      checkOutput("flush_s_tready", s_tready, 1);
      stepCycle();
    end
    flushIn = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axis_pingpong_ctrl.md
AXIS_PINGPONG_CTRL -- requirements
Module: axis_pingpong_ctrl

Interface
REQ-001 Parameter DD, default 2048: depth in beats of each of the two external BRAM banks.
REQ-002 Parameter AW, default $clog2(DD): bank address width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port list, in this order:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- s_tvalid  in  1  upstream beat valid.
- s_tlast  in  1  upstream end of packet.
- s_tready  out  1  controller accepts the upstream beat.
- wr_en  out  1  BRAM write strobe; the data path routes s_tdata to the BRAM.
- wr_bank  out  1  bank selected for write: 0 = bank A, 1 = bank B.
- wr_addr  out  AW  write address within the bank.
- rd_en  out  1  BRAM read strobe; registered BRAM output holds its value when rd_en=0.
- rd_bank  out  1  bank selected for read.
- rd_addr  out  AW  read address within the bank.
- m_tvalid  out  1  downstream beat valid; aligned with the BRAM read data.
- m_tlast  out  1  downstream end of packet.
- m_tready  in  1  downstream ready.
- bank_full  out  2  bit n=1 while bank n is FULL or DRAINING.

Function
REQ-005 Each bank has its own state machine with states EMPTY, FILLING, FULL and DRAINING, plus a length register (AW+1 bits) and a last-flag register.
REQ-006 Bank transitions:
- EMPTY->FILLING when the bank is selected by wr_bank.
- FILLING->FULL on the beat that closes the bank.
- FULL->DRAINING when the bank is selected by rd_bank.
- DRAINING->EMPTY on the final read issue.
REQ-007 s_tready is combinational and equals !rst && (state[wr_bank] is EMPTY or FILLING).
REQ-008 Beat acceptance:
- A beat is accepted when s_tvalid && s_tready.
- On acceptance: wr_en=1 with wr_addr = write count; the write count then increments.
- wr_en=0 on all other cycles.
REQ-009 Bank close: the bank closes on an accepted beat with s_tlast=1, or on the DD-th accepted beat.
- length is set to the beat count, 1 to DD.
- last-flag is set to s_tlast of the closing beat.
- wr_bank toggles and the write count clears on the next cycle.
REQ-010 If the newly selected write bank is not EMPTY, s_tready stays 0 until that bank returns to EMPTY. No beat is dropped or overwritten.
REQ-011 Read issue: rd_en = (state[rd_bank] is FULL or DRAINING) && (!m_tvalid || m_tready), with rd_addr = read count.
REQ-012 Output timing: m_tvalid is registered and set the cycle after rd_en=1. It clears when m_tready=1 and no new rd_en was issued.
REQ-013 m_tlast is registered with m_tvalid. It is 1 only for the final beat of a bank whose last-flag=1.
REQ-014 After the final read issue, rd_bank toggles and the read count clears.
REQ-015 Latency: the first m_tvalid occurs 2 cycles after the closing write beat, when m_tvalid was 0 and the other bank is idle.
REQ-016 Simultaneous events:
- Write and read on opposite banks in the same cycle are both permitted; full throughput is 1 beat per cycle.
- A bank reaching EMPTY becomes writable on the following cycle, never in the same cycle.
REQ-017 While m_tvalid=1 && m_tready=0, m_tvalid, m_tlast and the read pointer hold, and rd_en=0.

Reset
REQ-018 While rst=1 the following hold:
- Both banks EMPTY; wr_bank=0, rd_bank=0; all counts, lengths and flags are 0.
- Outputs: s_tready=0, wr_en=0, rd_en=0, m_tvalid=0, m_tlast=0, bank_full=2'b00.
REQ-019 Reset asserted mid-transfer discards all buffered data. The first cycle after rst deasserts has s_tready=1.

Configuration
REQ-020 Macro AXIS_PP_FLUSH_EN, when defined, adds input port flush (1 bit, placed after s_tready).
- flush=1 with the write bank FILLING and count>0 closes the bank with last-flag=1.
- If a beat is accepted in that same cycle, the beat is included in the closed bank.
- flush is ignored when the write bank is EMPTY or has count=0.
REQ-021 Without AXIS_PP_FLUSH_EN, the flush port is absent and banks close only per REQ-009.

Verification (DD=8)
REQ-022 Send 3 beats with tlast on beat 3, m_tready=1 -> wr_addr 0,1,2 in bank A; m_tvalid 3 beats; m_tlast on beat 3 only; bank_full[0] returns to 0.
REQ-023 Send 20 beats with no tlast, m_tready=0 -> banks A and B fill (8 beats each); s_tready=0 from beat 17; bank_full=2'b11.
REQ-024 Continue REQ-023 with m_tready=1 -> 16 beats out in order, bank A then B, with m_tlast=0; s_tready returns to 1 the cycle after bank A empties.
REQ-025 Continuous traffic, 4-beat packets, m_tready=1 -> sustained 1 beat per cycle after fill; wr_bank never equals rd_bank while both banks are active.
REQ-026 Pulse rst during bank A draining with 5 beats left -> m_tvalid=0 during reset; no further beats from the old packet; s_tready=1 one cycle after reset.
REQ-027 AXIS_PP_FLUSH_EN defined: 2 beats then flush=1 -> bank closes with length 2 and m_tlast on beat 2. Flush with count=0 -> no effect.
